// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencer and its helpers.
package core_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWrite  = 3'd4,
        StStall  = 3'd5,
        StHalt   = 3'd6,
        StError  = 3'd7
    } seq_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive waiting cycles; expired marks the TIMEOUT-th cycle of a wait.
module wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = run && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback with one-cycle
// stage-enable pulses, owns the PC and retired-instruction counter, and handles stall/halt/error.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_enabled,
    input  logic        fetch_done,
    output logic        decode_enabled,
    output logic        exec_enabled,
    output logic        mem_enabled,
    input  logic        mem_done,
    output logic        write_enabled,
    input  logic        is_mem_op,
    input  logic        is_halt,
    input  logic        is_jump_enabled,
    input  logic [31:0] jump_dest,
    input  logic        stall_req,
    output logic [31:0] pc,
    output logic [31:0] instr_count,
    output logic [2:0]  state_out,
    output logic        halted,
    output logic        error
);

    seq_state_t  r_state;
    logic        r_first;
    logic        r_fetch_en;
    logic        r_decode_en;
    logic        r_exec_en;
    logic        r_mem_en;
    logic        r_write_en;
    logic [31:0] r_pc;
    logic [31:0] r_instr_count;
    logic        r_halted;
    logic        r_error;
    logic        r_mem_op;
    logic        r_jump;
    logic [31:0] r_jump_dest;

    logic w_fetch_wait;
    logic w_mem_wait;
    logic w_run;
    logic w_clear;
    logic w_expired;
    logic w_mem_first;

    // The post-reset FETCH cycle only arms the first fetch pulse; waiting starts with the pulse.
    assign w_fetch_wait = (r_state == StFetch) && !r_first;
    assign w_mem_wait   = (r_state == StMem) && r_mem_op;
    assign w_run        = w_fetch_wait || w_mem_wait;
    assign w_clear      = !w_run || w_expired || (w_fetch_wait && fetch_done) ||
                          (w_mem_wait && mem_done);
    // A memory op's first MEM cycle is its pulse cycle; a non-memory op spends one cycle there.
    assign w_mem_first  = !r_mem_op || r_mem_en;

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .run    (w_run),
        .expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StFetch;
            r_first       <= 1'b1;
            r_fetch_en    <= 1'b0;
            r_decode_en   <= 1'b0;
            r_exec_en     <= 1'b0;
            r_mem_en      <= 1'b0;
            r_write_en    <= 1'b0;
            r_pc          <= RESET_PC;
            r_instr_count <= 32'd0;
            r_halted      <= 1'b0;
            r_error       <= 1'b0;
            r_mem_op      <= 1'b0;
            r_jump        <= 1'b0;
            r_jump_dest   <= 32'd0;
        end else begin
            r_fetch_en  <= 1'b0;
            r_decode_en <= 1'b0;
            r_exec_en   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_write_en  <= 1'b0;

            unique case (r_state)
                StFetch: begin
                    if (r_first) begin
                        r_first    <= 1'b0;
                        r_fetch_en <= 1'b1;
                    end else if (fetch_done) begin
                        r_state     <= StDecode;
                        r_decode_en <= 1'b1;
                    end else if (w_expired) begin
                        r_state <= StError;
                        r_error <= 1'b1;
                    end
                end
                StDecode: begin
                    r_state   <= StExec;
                    r_exec_en <= 1'b1;
                end
                StExec: begin
                    if (is_halt) begin
                        r_state  <= StHalt;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= StMem;
                        r_mem_op <= is_mem_op;
                        r_mem_en <= is_mem_op;
                    end
                end
                StMem: begin
                    if (w_mem_first) begin
                        r_jump      <= is_jump_enabled;
                        r_jump_dest <= jump_dest;
                    end
                    if (!r_mem_op || mem_done) begin
                        r_state    <= StWrite;
                        r_write_en <= 1'b1;
                    end else if (w_expired) begin
                        r_state <= StError;
                        r_error <= 1'b1;
                    end
                end
                StWrite: begin
                    r_instr_count <= r_instr_count + 32'd1;
                    if (r_jump && is_misaligned(r_jump_dest)) begin
                        r_state <= StError;
                        r_error <= 1'b1;
                    end else begin
                        r_pc <= r_jump ? r_jump_dest : r_pc + INSTR_BYTES;
                        if (stall_req) begin
                            r_state <= StStall;
                        end else begin
                            r_state    <= StFetch;
                            r_fetch_en <= 1'b1;
                        end
                    end
                end
                StStall: begin
                    if (!stall_req) begin
                        r_state    <= StFetch;
                        r_fetch_en <= 1'b1;
                    end
                end
                StHalt: begin
                    r_halted <= 1'b1;
                end
                StError: begin
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    assign fetch_enabled  = r_fetch_en;
    assign decode_enabled = r_decode_en;
    assign exec_enabled   = r_exec_en;
    assign mem_enabled    = r_mem_en;
    assign write_enabled  = r_write_en;
    assign pc             = r_pc;
    assign instr_count    = r_instr_count;
    assign state_out      = r_state;
    assign halted         = r_halted;
    assign error          = r_error;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench: an instruction-level timeline model predicts every cycle of the sequencer.
module tb_core_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          TIMEOUT  = 4;
    localparam logic [4:0]  EN_F = 5'b10000;
    localparam logic [4:0]  EN_D = 5'b01000;
    localparam logic [4:0]  EN_E = 5'b00100;
    localparam logic [4:0]  EN_M = 5'b00010;
    localparam logic [4:0]  EN_W = 5'b00001;
    localparam logic [4:0]  EN_0 = 5'b00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_enabled, decode_enabled, exec_enabled, mem_enabled, write_enabled;
    logic        fetch_done, mem_done, is_mem_op, is_halt, is_jump_enabled, stall_req;
    logic [31:0] jump_dest, pc, instr_count;
    logic [2:0]  state_out;
    logic        halted, error;

    core_sequencer #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_enabled  (fetch_enabled),
        .fetch_done     (fetch_done),
        .decode_enabled (decode_enabled),
        .exec_enabled   (exec_enabled),
        .mem_enabled    (mem_enabled),
        .mem_done       (mem_done),
        .write_enabled  (write_enabled),
        .is_mem_op      (is_mem_op),
        .is_halt        (is_halt),
        .is_jump_enabled(is_jump_enabled),
        .jump_dest      (jump_dest),
        .stall_req      (stall_req),
        .pc             (pc),
        .instr_count    (instr_count),
        .state_out      (state_out),
        .halted         (halted),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [4:0]  en;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        halted;
        logic        error;
    } obs_t;

    typedef struct packed {
        logic        rst, fd, md, mo, ih, ij, sr;
        logic [31:0] jd;
    } stim_t;

    obs_t  exp_q[$];
    obs_t  act_q[$];
    stim_t stim_q[$];
    bit    chk_q[$];

    logic [31:0] m_pc, m_cnt;
    logic        m_halted, m_error;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic stim_t rnd_stim();
        stim_t s;
        s.rst = 1'b0;
        s.fd  = 1'($urandom_range(0, 1));
        s.md  = 1'($urandom_range(0, 1));
        s.mo  = 1'($urandom_range(0, 1));
        s.ih  = 1'($urandom_range(0, 1));
        s.ij  = 1'($urandom_range(0, 1));
        s.sr  = 1'($urandom_range(0, 1));
        s.jd  = $urandom;
        return s;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d en=%b pc=%h cnt=%0d halted=%b error=%b",
                         o.st, o.en, o.pc, o.cnt, o.halted, o.error);
    endfunction

    function automatic void push(input logic [2:0] st, input logic [4:0] en, input stim_t s);
        obs_t o;
        o.st = st; o.en = en; o.pc = m_pc; o.cnt = m_cnt;
        o.halted = m_halted; o.error = m_error;
        exp_q.push_back(o); stim_q.push_back(s); chk_q.push_back(1'b1);
    endfunction

    function automatic void clear_q();
        exp_q.delete(); act_q.delete(); stim_q.delete(); chk_q.delete();
    endfunction

    // One reset cycle (unchecked), then the arming FETCH cycle with reset values.
    function automatic void gen_reset();
        stim_t s;
        s = rnd_stim();
        s.rst = 1'b1;
        exp_q.push_back('0); stim_q.push_back(s); chk_q.push_back(1'b0);
        m_pc = RESET_PC; m_cnt = 32'd0; m_halted = 1'b0; m_error = 1'b0;
        s = rnd_stim();
        s.fd = 1'b0;
        push(3'd0, EN_0, s);
    endfunction

    // fw/mw: cycles after the fetch/mem pulse before done; hold: extra stall_req cycles after WRITE.
    function automatic void gen_instr(input int fw, input bit mo, input int mw, input bit jmp,
                                      input logic [31:0] dest, input bit halt, input int hold);
        stim_t s;
        int    n;
        n = (fw >= TIMEOUT) ? TIMEOUT : fw + 1;
        for (int i = 0; i < n; i++) begin
            s = rnd_stim(); s.fd = (i == fw);
            push(3'd0, (i == 0) ? EN_F : EN_0, s);
        end
        if (fw >= TIMEOUT) begin m_error = 1'b1; return; end
        s = rnd_stim();
        push(3'd1, EN_D, s);
        s = rnd_stim(); s.mo = mo; s.ih = halt;
        push(3'd2, EN_E, s);
        if (halt) begin m_halted = 1'b1; return; end
        n = !mo ? 1 : ((mw >= TIMEOUT) ? TIMEOUT : mw + 1);
        for (int i = 0; i < n; i++) begin
            s = rnd_stim();
            if (i == 0) begin s.mo = mo; s.ij = jmp; s.jd = dest; end
            if (mo) s.md = (i == mw);
            push(3'd3, (mo && i == 0) ? EN_M : EN_0, s);
        end
        if (mo && mw >= TIMEOUT) begin m_error = 1'b1; return; end
        s = rnd_stim(); s.sr = (hold > 0);
        push(3'd4, EN_W, s);
        m_cnt = m_cnt + 32'd1;
        if (jmp && dest[1:0] != 2'b00) begin m_error = 1'b1; return; end
        m_pc = jmp ? dest : m_pc + 32'd4;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                s = rnd_stim(); s.sr = 1'b1; push(3'd5, EN_0, s);
            end
            s = rnd_stim(); s.sr = 1'b0; push(3'd5, EN_0, s);
        end
    endfunction

    function automatic void gen_dead(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = rnd_stim();
            push(m_error ? 3'd7 : 3'd6, EN_0, s);
        end
    endfunction

    // Drives the queued stimulus one cycle per negedge and records the outputs of each cycle.
    task automatic play();
        stim_t s;
        obs_t  o;
        act_q.delete();
        for (int i = 0; i < stim_q.size(); i++) begin
            o.st = state_out;
            o.en = {fetch_enabled, decode_enabled, exec_enabled, mem_enabled, write_enabled};
            o.pc = pc; o.cnt = instr_count; o.halted = halted; o.error = error;
            act_q.push_back(o);
            s = stim_q[i];
            rst = s.rst; fetch_done = s.fd; mem_done = s.md; is_mem_op = s.mo;
            is_halt = s.ih; is_jump_enabled = s.ij; stall_req = s.sr; jump_dest = s.jd;
            @(negedge clk);
        end
    endtask

    function automatic int pulse_idx(input int k);
        int seen = 0;
        for (int i = 0; i < act_q.size(); i++) begin
            if (chk_q[i] && act_q[i].en[4]) begin
                if (seen == k) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int count_state(input logic [2:0] st);
        int n = 0;
        for (int i = 0; i < act_q.size(); i++) if (chk_q[i] && act_q[i].st == st) n++;
        return n;
    endfunction

    task automatic test_reset();
        clear_q();
        gen_reset();
        gen_instr(0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 0);
        play();
        n_checks++;
        if (act_q[1].pc !== RESET_PC || act_q[1].cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_values: got pc=%h cnt=%0d, want pc=%h cnt=0",
                     act_q[1].pc, act_q[1].cnt, RESET_PC);
        end
        n_checks++;
        if (act_q[1].st !== 3'd0 || act_q[1].en !== EN_0 || act_q[1].halted !== 1'b0 ||
            act_q[1].error !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %s, want st=0 en=00000 halted=0 error=0",
                     fmt(act_q[1]));
        end
        for (int i = 0; i < exp_q.size(); i++) if (chk_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL reset_trace cycle %0d: got %s, want %s", i, fmt(act_q[i]),
                         fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_sequential();
        int p;
        clear_q();
        gen_reset();
        for (int k = 0; k < 11; k++) gen_instr(0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 0);
        play();
        for (int i = 0; i < exp_q.size(); i++) if (chk_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL seq_trace cycle %0d: got %s, want %s", i, fmt(act_q[i]),
                         fmt(exp_q[i]));
            end
        end
        for (int k = 1; k < 11; k++) begin
            n_checks++;
            if (pulse_idx(k) - pulse_idx(k - 1) !== 5) begin
                n_errors++;
                $display("FAIL seq_period pulse %0d: got gap %0d, want 5", k,
                         pulse_idx(k) - pulse_idx(k - 1));
            end
        end
        p = pulse_idx(10);
        n_checks++;
        if (p < 0 || act_q[p].pc !== 32'h0000_0128 || act_q[p].cnt !== 32'd10) begin
            n_errors++;
            $display("FAIL seq_after_10: got idx=%0d pc=%h cnt=%0d, want pc=00000128 cnt=10",
                     p, (p < 0) ? 32'd0 : act_q[p].pc, (p < 0) ? 32'd0 : act_q[p].cnt);
        end
    endtask

    task automatic test_mem_wait();
        int m0, w0, nm;
        clear_q();
        gen_reset();
        gen_instr(0, 1'b1, 3, 1'b0, 32'd0, 1'b0, 0);
        gen_instr(0, 1'b1, 0, 1'b0, 32'd0, 1'b0, 0);
        play();
        for (int i = 0; i < exp_q.size(); i++) if (chk_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL mem_trace cycle %0d: got %s, want %s", i, fmt(act_q[i]),
                         fmt(exp_q[i]));
            end
        end
        m0 = -1; w0 = -1; nm = 0;
        for (int i = 0; i < pulse_idx(1); i++) begin
            if (act_q[i].st == 3'd3 && m0 < 0) m0 = i;
            if (act_q[i].st == 3'd4 && w0 < 0) w0 = i;
            if (act_q[i].en[1]) nm++;
        end
        n_checks++;
        if (nm !== 1 || w0 - m0 !== 4) begin
            n_errors++;
            $display("FAIL mem_pulse: got mem pulses=%0d mem->write=%0d, want 1 and 4",
                     nm, w0 - m0);
        end
        n_checks++;
        if (pulse_idx(1) - pulse_idx(0) !== 8) begin
            n_errors++;
            $display("FAIL mem_latency: got %0d cycles, want 8", pulse_idx(1) - pulse_idx(0));
        end
    endtask

    task automatic test_jump();
        obs_t last;
        clear_q();
        gen_reset();
        gen_instr(1, 1'b0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 0);
        gen_instr(0, 1'b1, 1, 1'b0, 32'd0, 1'b0, 0);
        gen_instr(0, 1'b0, 0, 1'b1, 32'h0000_0040, 1'b0, 0);
        gen_instr(0, 1'b0, 0, 1'b1, 32'h0000_0042, 1'b0, 0);
        gen_dead(8);
        play();
        for (int i = 0; i < exp_q.size(); i++) if (chk_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL jump_trace cycle %0d: got %s, want %s", i, fmt(act_q[i]),
                         fmt(exp_q[i]));
            end
        end
        n_checks++;
        if (pulse_idx(2) < 0 || act_q[pulse_idx(2)].pc !== 32'd0) begin
            n_errors++;
            $display("FAIL jump_wrap: pc after FFFFFFFC+4 got %h, want 00000000",
                     (pulse_idx(2) < 0) ? 32'hx : act_q[pulse_idx(2)].pc);
        end
        n_checks++;
        if (pulse_idx(3) < 0 || act_q[pulse_idx(3)].pc !== 32'h40) begin
            n_errors++;
            $display("FAIL jump_target: got pc=%h, want 00000040",
                     (pulse_idx(3) < 0) ? 32'hx : act_q[pulse_idx(3)].pc);
        end
        last = act_q[act_q.size() - 1];
        n_checks++;
        if (last.st !== 3'd7 || last.error !== 1'b1 || last.pc !== 32'h40 ||
            last.cnt !== 32'd4 || pulse_idx(4) !== -1) begin
            n_errors++;
            $display("FAIL jump_misaligned: got %s extra_fetch_idx=%0d, want st=7 error=1 pc=40 cnt=4 no fetch",
                     fmt(last), pulse_idx(4));
        end
    endtask

    task automatic test_stall();
        int j;
        clear_q();
        gen_reset();
        gen_instr(0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 5);
        gen_instr(0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 0);
        play();
        for (int i = 0; i < exp_q.size(); i++) if (chk_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL stall_trace cycle %0d: got %s, want %s", i, fmt(act_q[i]),
                         fmt(exp_q[i]));
            end
        end
        n_checks++;
        if (count_state(3'd5) !== 6) begin
            n_errors++;
            $display("FAIL stall_len: got %0d STALL cycles, want 6", count_state(3'd5));
        end
        j = -1;
        for (int i = 0; i < act_q.size(); i++) if (act_q[i].st == 3'd5) j = i;
        n_checks++;
        if (j < 0 || act_q[j + 1].en !== EN_F) begin
            n_errors++;
            $display("FAIL stall_release: got en=%b after last STALL, want %b",
                     (j < 0) ? 5'bx : act_q[j + 1].en, EN_F);
        end
    endtask

    task automatic test_timeout();
        int e;
        clear_q();
        gen_reset();
        gen_instr(TIMEOUT - 1, 1'b0, 0, 1'b0, 32'd0, 1'b0, 0);
        gen_instr(0, 1'b1, TIMEOUT - 1, 1'b0, 32'd0, 1'b0, 0);
        gen_instr(0, 1'b1, TIMEOUT, 1'b0, 32'd0, 1'b0, 0);
        gen_dead(5);
        gen_reset();
        gen_instr(1000, 1'b0, 0, 1'b0, 32'd0, 1'b0, 0);
        gen_dead(6);
        play();
        for (int i = 0; i < exp_q.size(); i++) if (chk_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL timeout_trace cycle %0d: got %s, want %s", i, fmt(act_q[i]),
                         fmt(exp_q[i]));
            end
        end
        e = -1;
        for (int i = pulse_idx(3); i >= 0 && i < act_q.size(); i++) begin
            if (act_q[i].error === 1'b1) begin e = i; break; end
        end
        n_checks++;
        if (e - pulse_idx(3) !== TIMEOUT) begin
            n_errors++;
            $display("FAIL fetch_timeout: error rose %0d cycles after fetch pulse, want %0d",
                     e - pulse_idx(3), TIMEOUT);
        end
    endtask

    task automatic test_halt();
        obs_t last;
        clear_q();
        gen_reset();
        gen_instr(2, 1'b0, 0, 1'b0, 32'd0, 1'b0, 0);
        gen_instr(0, 1'b1, 2, 1'b0, 32'd0, 1'b1, 0);
        gen_dead(8);
        play();
        for (int i = 0; i < exp_q.size(); i++) if (chk_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL halt_trace cycle %0d: got %s, want %s", i, fmt(act_q[i]),
                         fmt(exp_q[i]));
            end
        end
        last = act_q[act_q.size() - 1];
        n_checks++;
        if (last.st !== 3'd6 || last.halted !== 1'b1 || last.cnt !== 32'd1 ||
            last.pc !== RESET_PC + 32'd4) begin
            n_errors++;
            $display("FAIL halt_final: got %s, want st=6 halted=1 cnt=1 pc=%h", fmt(last),
                     RESET_PC + 32'd4);
        end
    endtask

    task automatic test_reset_mid_mem();
        int keep;
        logic [31:0] save_pc, save_cnt;
        clear_q();
        gen_reset();
        gen_instr(0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 0);
        save_pc = m_pc; save_cnt = m_cnt;
        keep = exp_q.size() + 5;
        gen_instr(0, 1'b1, 3, 1'b0, 32'd0, 1'b0, 0);
        while (exp_q.size() > keep) begin
            void'(exp_q.pop_back()); void'(stim_q.pop_back()); void'(chk_q.pop_back());
        end
        m_pc = save_pc; m_cnt = save_cnt;
        gen_reset();
        gen_instr(0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 0);
        play();
        for (int i = 0; i < exp_q.size(); i++) if (chk_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL abort_trace cycle %0d: got %s, want %s", i, fmt(act_q[i]),
                         fmt(exp_q[i]));
            end
        end
        n_checks++;
        if (act_q[keep - 1].st !== 3'd3 || act_q[keep + 1].pc !== RESET_PC ||
            act_q[keep + 1].cnt !== 32'd0 || act_q[keep + 1].st !== 3'd0 ||
            act_q[keep + 1].en !== EN_0) begin
            n_errors++;
            $display("FAIL abort_reset: got before=%0d after %s, want before=3 st=0 en=0 pc=%h cnt=0",
                     act_q[keep - 1].st, fmt(act_q[keep + 1]), RESET_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        clear_q();
        gen_reset();
        for (int k = 0; k < 40; k++) begin
            d = $urandom & 32'hFFFF_FFFC;
            gen_instr($urandom_range(0, TIMEOUT - 1), 1'($urandom_range(0, 1)),
                      $urandom_range(0, TIMEOUT - 1), 1'($urandom_range(0, 1)), d, 1'b0,
                      $urandom_range(0, 3));
        end
        play();
        for (int i = 0; i < exp_q.size(); i++) if (chk_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL random_trace cycle %0d: got %s, want %s", i, fmt(act_q[i]),
                         fmt(exp_q[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; fetch_done = 1'b0; mem_done = 1'b0; is_mem_op = 1'b0; is_halt = 1'b0;
        is_jump_enabled = 1'b0; stall_req = 1'b0; jump_dest = 32'd0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_mem_wait();
        test_jump();
        test_stall();
        test_timeout();
        test_halt();
        test_reset_mid_mem();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the core. Sequences one instruction at a time through fetch, decode, execute, memory and writeback by issuing single-cycle stage-enable pulses and waiting on memory handshakes. Owns the architectural PC, which it updates from the execute stage's jump outputs. Also provides halt, stall, timeout and error handling.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles to wait for fetch_done or mem_done before entering ERROR (must be >= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
fetch_enabled  out  1  one-cycle pulse: start instruction fetch at pc
fetch_done  in  1  instruction memory has returned the instruction
decode_enabled  out  1  one-cycle pulse: decode stage latches
exec_enabled  out  1  one-cycle pulse: execute stage latches
mem_enabled  out  1  one-cycle pulse: start data memory access
mem_done  in  1  data memory access complete
write_enabled  out  1  one-cycle pulse: register file commit
is_mem_op  in  1  from decode: current instruction is load/store
is_halt  in  1  from decode: ecall/unsupported opcode, stop the core
is_jump_enabled  in  1  from execute: take jump/branch
jump_dest  in  32  from execute: jump target
stall_req  in  1  external hold request (debugger/UART loader)
pc  out  32  current instruction address
instr_count  out  32  retired instruction counter
state_out  out  3  current FSM state encoding (debug)
halted  out  1  core halted (sticky until reset)
error  out  1  timeout or misaligned jump (sticky until reset)

Behaviour:
- Clock clk; one clock domain. Reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: state=FETCH with first-cycle flag set, all *_enabled=0, pc=RESET_PC, instr_count=0, halted=0, error=0, wait counter=0.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4, STALL=5, HALT=6, ERROR=7.
- Each *_enabled output is high only in the first cycle of a visit to its state. It is never re-asserted while waiting in that state.
- FETCH: fetch_enabled pulses in the first cycle. fetch_done is sampled every FETCH cycle, including the pulse cycle. On fetch_done, go to DECODE.
- DECODE: decode_enabled for 1 cycle, then go to EXEC.
- EXEC: exec_enabled for 1 cycle. is_halt is sampled here (decode outputs are valid).
  - is_halt=1: go to HALT; no exec pulse effect is committed, pc and instr_count are unchanged.
  - Otherwise go to MEM.
- MEM: first cycle samples is_mem_op and latches is_jump_enabled/jump_dest (execute outputs are valid).
  - is_mem_op=0: go to WRITE after 1 cycle, mem_enabled stays 0.
  - is_mem_op=1: mem_enabled pulses in the first cycle. Wait for mem_done (mem_done in the pulse cycle is accepted), then go to WRITE.
- WRITE: write_enabled for 1 cycle.
  - pc <= latched jump ? latched jump_dest : pc+4 (32-bit wrap at 2^32).
  - instr_count <= instr_count+1 (wraps).
  - Next state is STALL if stall_req=1, else FETCH.
- Misaligned jump: if the latched jump is taken and jump_dest[1:0]!=0, set error=1 and go to ERROR from WRITE. write_enabled still pulses; pc is unchanged; instr_count still increments.
- STALL: all enables 0. Return to FETCH (new first-cycle pulse) in the cycle after stall_req is sampled 0. stall_req is ignored in all other states.
- Timeout: the wait counter counts cycles spent in FETCH or MEM-with-mem-op and clears on every state change. On reaching TIMEOUT without the done signal, set error=1 and go to ERROR.
- HALT: halted=1. ERROR: error=1. Both are absorbing until rst. Late fetch_done/mem_done pulses in these states are ignored.
- fetch_done/mem_done asserted outside their wait state are ignored.
- rst asserted mid-instruction aborts at the next edge to reset values. The in-flight instruction is not counted.
- Minimum latency with zero-wait memories: 5 cycles per non-memory instruction, 5 cycles per memory instruction with mem_done in the pulse cycle.

Decomposition:
- Shared package core_pkg: state enum seq_state_t (3-bit encodings above) and constant INSTR_BYTES=4.
- One sub-module is natural: wait_timer (TIMEOUT parameter; inputs clear and run; output expired).

Test Plan:
- Reset, RESET_PC=0x100, fetch_done held 1, is_mem_op=0, no jumps, 10 instructions -> fetch_enabled pulses every 5 cycles; pc steps 0x100..0x128; instr_count=10.
- is_mem_op=1, mem_done 3 cycles after mem_enabled -> mem_enabled high exactly 1 cycle; WRITE 4 cycles after MEM entry; instruction takes 8 cycles.
- is_jump_enabled=1 with jump_dest=0x40 in MEM -> next fetch pc=0x40. jump_dest=0x42 -> error=1, state_out=7, pc unchanged, no further fetch_enabled.
- stall_req=1 during WRITE, released 6 cycles later -> state_out=5 for the hold period; fetch_enabled pulses the cycle after release.
- TIMEOUT=4, fetch_done never asserted -> error=1 after 4 FETCH cycles. is_halt=1 at EXEC -> halted=1, instr_count unchanged.
- rst asserted during MEM wait -> next cycle pc=RESET_PC, instr_count=0, all enables 0, state_out=0.
